// File: rtl/pe_grid_12x14.sv
// Weight-stationary ROWS x COLS processing-element grid: per-column fixed-point MAC chain with
// registered psum outputs. Define PE_GRID_SATURATE_EN to clamp column sums instead of wrapping.
module pe_grid_12x14 #(
   parameter int ROWS   = 12,
   parameter int COLS   = 14,
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8,
   parameter int TAG_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] image_val_vec   [0:COLS-1],
   input  logic              valid_x_vec     [0:COLS-1],
   input  logic [DATA_W-1:0] row_weight_vals [0:COLS-1],
   input  logic [TAG_W-1:0]  tag_row,
   input  logic              valid_y,
   input  logic [DATA_W-1:0] psum_ins        [0:COLS-1],
   output logic [DATA_W-1:0] psum_outs       [0:COLS-1]
);

   localparam int PROD_W = 2 * DATA_W;
   // Headroom for ROWS products plus the incoming psum without loss.
   localparam int SUM_W  = DATA_W + $clog2(ROWS + 1) + 1;

   logic [DATA_W-1:0] w_q   [0:ROWS-1][0:COLS-1];
   logic [DATA_W-1:0] col_d [0:COLS-1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               w_q[r][c] <= '0;
            end
         end
      end else if (valid_y) begin
         // Tags at or beyond ROWS match no row and are dropped.
         for (int r = 0; r < ROWS; r++) begin
            if (int'(tag_row) == r) begin
               for (int c = 0; c < COLS; c++) begin
                  w_q[r][c] <= row_weight_vals[c];
               end
            end
         end
      end
   end

   always_comb begin
      logic signed [SUM_W-1:0]  acc;
      logic signed [PROD_W-1:0] full;
      logic signed [DATA_W-1:0] prod;
      logic        [SUM_W-DATA_W:0] top;
      acc  = '0;
      full = '0;
      prod = '0;
      top  = '0;
      for (int c = 0; c < COLS; c++) begin
         acc = SUM_W'($signed(psum_ins[c]));
         for (int r = 0; r < ROWS; r++) begin
            full = PROD_W'($signed(w_q[r][c])) * PROD_W'($signed(image_val_vec[c]));
            prod = DATA_W'(full >>> FRAC_W);
            acc  = acc + SUM_W'(prod);
         end
`ifdef PE_GRID_SATURATE_EN
         // Fits in DATA_W only if every bit from the sign position up agrees.
         top = acc[SUM_W-1:DATA_W-1];
         if (top != '0 && top != '1) begin
            col_d[c] = acc[SUM_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
         end else begin
            col_d[c] = DATA_W'(acc);
         end
`else
         col_d[c] = DATA_W'(acc);
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < COLS; c++) begin
            psum_outs[c] <= '0;
         end
      end else begin
         for (int c = 0; c < COLS; c++) begin
            if (valid_x_vec[c]) begin
               psum_outs[c] <= col_d[c];
            end
         end
      end
   end

endmodule

// File: tb/tb_pe_grid_12x14.sv
// Directed self-checking bench for pe_grid_12x14 (default 12x14, Q8.8); honours
// PE_GRID_SATURATE_EN for the overflow expectations.
module tb_pe_grid_12x14;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] image_val_vec   [0:13];
   logic        valid_x_vec     [0:13];
   logic [15:0] row_weight_vals [0:13];
   logic [3:0]  tag_row;
   logic        valid_y;
   logic [15:0] psum_ins        [0:13];
   logic [15:0] psum_outs       [0:13];

   int errors = 0;
   int checks = 0;

   pe_grid_12x14 dut (
      .clk             (clk),
      .rst             (rst),
      .image_val_vec   (image_val_vec),
      .valid_x_vec     (valid_x_vec),
      .row_weight_vals (row_weight_vals),
      .tag_row         (tag_row),
      .valid_y         (valid_y),
      .psum_ins        (psum_ins),
      .psum_outs       (psum_outs)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Columns below n expect e_lo, the rest e_hi.
   task automatic check_cols(input string tag, input int n, input logic [15:0] e_lo,
                             input logic [15:0] e_hi);
      for (int c = 0; c < 14; c++) begin
         check($sformatf("%s_c%0d", tag, c), psum_outs[c], (c < n) ? e_lo : e_hi);
      end
   endtask

   task automatic load_row(input int r, input int n, input logic [15:0] wv);
      tag_row = 4'(r);
      valid_y = 1'b1;
      for (int c = 0; c < 14; c++) row_weight_vals[c] = (c < n) ? wv : 16'h0000;
      step();
      valid_y = 1'b0;
   endtask

   task automatic compute(input logic [15:0] x, input logic [15:0] pin, input int nvalid);
      for (int c = 0; c < 14; c++) begin
         image_val_vec[c] = x;
         psum_ins[c]      = pin;
         valid_x_vec[c]   = (c < nvalid);
      end
      step();
      for (int c = 0; c < 14; c++) valid_x_vec[c] = 1'b0;
   endtask

   initial begin
      logic [15:0] exp_pos;
      logic [15:0] exp_neg;
      tag_row = '0;
      valid_y = 1'b0;
      for (int c = 0; c < 14; c++) begin
         image_val_vec[c]   = '0;
         valid_x_vec[c]     = 1'b0;
         row_weight_vals[c] = '0;
         psum_ins[c]        = '0;
      end

      // Reset asserted between edges with random activity on every input.
      #2;
      rst = 1'b0;
      valid_y = 1'b1;
      tag_row = 4'($urandom_range(0, 11));
      for (int c = 0; c < 14; c++) begin
         image_val_vec[c]   = 16'($urandom);
         row_weight_vals[c] = 16'($urandom);
         psum_ins[c]        = 16'($urandom);
         valid_x_vec[c]     = 1'b1;
      end
      #1;
      check_cols("rst_async", 14, 16'h0000, 16'h0000);
      step();
      step();
      check_cols("rst_held", 14, 16'h0000, 16'h0000);
      valid_y = 1'b0;
      for (int c = 0; c < 14; c++) valid_x_vec[c] = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      step();
      step();
      check_cols("post_rst", 14, 16'h0000, 16'h0000);

      // 6 rows of 1.0 in cols 0..5; six 1.0*1.0 products per column.
      for (int r = 0; r < 6; r++) load_row(r, 6, 16'h0100);
      compute(16'h0100, 16'h0000, 6);
      check_cols("kernel", 6, 16'h0600, 16'h0000);

      // Out-of-range tags must not disturb any row.
      load_row(12, 14, 16'h0100);
      load_row(15, 14, 16'h0100);
      compute(16'h0100, 16'h0000, 14);
      check_cols("badtag", 6, 16'h0600, 16'h0000);

      // Hold with valid_x low while inputs churn.
      for (int c = 0; c < 14; c++) begin
         image_val_vec[c] = 16'($urandom);
         psum_ins[c]      = 16'($urandom);
      end
      step();
      step();
      check_cols("hold", 6, 16'h0600, 16'h0000);

      // Per-column patterns on a sparse valid subset.
      for (int c = 0; c < 14; c++) begin
         image_val_vec[c] = 16'h0100;
         psum_ins[c]      = 16'h0000;
      end
      image_val_vec[0] = 16'h0200; psum_ins[0] = 16'h0010; valid_x_vec[0] = 1'b1;
      image_val_vec[1] = 16'hFF00;                        valid_x_vec[1] = 1'b1;
      image_val_vec[2] = 16'h0080;                        valid_x_vec[2] = 1'b1;
      psum_ins[7] = 16'h1234;                             valid_x_vec[7] = 1'b1;
      step();
      for (int c = 0; c < 14; c++) valid_x_vec[c] = 1'b0;
      check("mix_c0", psum_outs[0], 16'h0C10);
      check("mix_c1", psum_outs[1], 16'hFA00);
      check("mix_c2", psum_outs[2], 16'h0300);
      check("mix_c3_hold", psum_outs[3], 16'h0600);
      check("mix_c7", psum_outs[7], 16'h1234);
      check("mix_c8_hold", psum_outs[8], 16'h0000);

      // Load row 6 in the same cycle as a compute: old weights first, new ones next.
      for (int c = 0; c < 14; c++) begin
         image_val_vec[c]   = 16'h0100;
         psum_ins[c]        = 16'h0000;
         valid_x_vec[c]     = 1'b1;
         row_weight_vals[c] = 16'h0100;
      end
      tag_row = 4'd6;
      valid_y = 1'b1;
      step();
      valid_y = 1'b0;
      check_cols("coll_old", 6, 16'h0600, 16'h0000);
      step();
      check_cols("coll_new", 6, 16'h0700, 16'h0100);
      for (int c = 0; c < 14; c++) valid_x_vec[c] = 1'b0;

      // Twelve 0x7F00 weights in col 0: sum 0x5F400 overflows 16 bits either way.
`ifdef PE_GRID_SATURATE_EN
      exp_pos = 16'h7FFF;
      exp_neg = 16'h8000;
`else
      exp_pos = 16'hF400;
      exp_neg = 16'h0C00;
`endif
      for (int r = 0; r < 12; r++) load_row(r, 1, 16'h7F00);
      compute(16'h0100, 16'h0000, 14);
      check("ovf_pos_c0", psum_outs[0], exp_pos);
      check("ovf_pos_c1", psum_outs[1], 16'h0000);
      check("ovf_pos_c13", psum_outs[13], 16'h0000);
      compute(16'hFF00, 16'h0000, 1);
      check("ovf_neg_c0", psum_outs[0], exp_neg);

      // Asynchronous reset mid-cycle clears outputs and weights.
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check("midrst_c0", psum_outs[0], 16'h0000);
      @(negedge clk);
      rst = 1'b1;
      compute(16'h0100, 16'h0005, 14);
      check_cols("post_midrst", 14, 16'h0005, 16'h0005);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pe_grid_12x14.md
PE_GRID_12X14 -- requirements
Module: pe_grid_12x14

Interface
REQ-001 SHALL have parameter ROWS, default 12: number of PE rows, with row index 0..ROWS-1.
REQ-002 SHALL have parameter COLS, default 14: number of PE columns and the length of every vector port.
REQ-003 SHALL have parameter DATA_W, default 16: width of weights, image values and partial sums (psums).
REQ-004 SHALL have parameter FRAC_W, default 8: fractional bits of the signed fixed-point format (Q8.8; 16'h0100 = 1.0).
REQ-005 SHALL have parameter TAG_W, default 4: width of tag_row.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port image_val_vec[0:COLS-1], input, DATA_W each: image value per column.
REQ-009 SHALL have port valid_x_vec[0:COLS-1], input, 1 bit each: image value valid, per column.
REQ-010 SHALL have port row_weight_vals[0:COLS-1], input, DATA_W each: one kernel row, one weight per column.
REQ-011 SHALL have port tag_row, input, TAG_W: target PE row for the weight broadcast.
REQ-012 SHALL have port valid_y, input, 1 bit: weight broadcast strobe.
REQ-013 SHALL have port psum_ins[0:COLS-1], input, DATA_W each: incoming partial sum per column.
REQ-014 SHALL have port psum_outs[0:COLS-1], output, DATA_W each: registered partial sum per column.

Function
REQ-015 SHALL contain ROWS x COLS PEs; PE(r,c) holds one signed DATA_W weight register w[r][c].
REQ-016 Weight load: on a clock edge where valid_y=1 and tag_row=r with r<ROWS, each PE(r,c) SHALL latch row_weight_vals[c]; all other rows are unchanged.
REQ-017 A valid_y=1 cycle with tag_row>=ROWS SHALL change no weight.
REQ-018 Weights SHALL persist until overwritten or reset; valid_y=0 leaves all weights unchanged.
REQ-019 image_val_vec[c] SHALL be broadcast to every PE in column c.
REQ-020 Each PE product SHALL be p[r][c] = (w[r][c] * image_val_vec[c]) as a signed 2*DATA_W product, arithmetic-shifted right by FRAC_W, then truncated to DATA_W.
REQ-021 Column sum SHALL be S[c] = psum_ins[c] + sum of p[r][c] over r=0..ROWS-1, combinational through the column and modulo 2^DATA_W (wrap) by default.
REQ-022 On a clock edge where valid_x_vec[c]=1, psum_outs[c] SHALL take S[c]; latency is 1 cycle.
REQ-023 When valid_x_vec[c]=0, psum_outs[c] SHALL hold its value.
REQ-024 Columns SHALL be fully independent; any subset of valid_x_vec may be asserted in a cycle.
REQ-025 If valid_y and valid_x are both 1 in the same cycle, the compute SHALL use the pre-edge (old) weights; the new weights apply from the next cycle.
REQ-026 The block SHALL have no handshake back-pressure; inputs are sampled every cycle.

Reset
REQ-027 While rst=0, all weights and all psum_outs SHALL be 0 immediately, independent of clk.
REQ-028 Deasserting rst mid-operation SHALL resume with all weights and outputs at 0; no earlier weight load is retained.

Configuration
REQ-029 Macro PE_GRID_SATURATE_EN SHALL select the column-sum overflow behaviour.
REQ-030 When PE_GRID_SATURATE_EN is defined, the column accumulation SHALL be computed at full width and clamped to signed range 16'h7FFF / 16'h8000 before registering.
REQ-031 When PE_GRID_SATURATE_EN is undefined, the column accumulation SHALL wrap modulo 2^DATA_W.

Verification
REQ-032 Reset: drive rst=0 with random inputs -> all psum_outs=0 at once; after release with valid_x all 0 -> outputs stay 0.
REQ-033 Kernel load: load rows 0..5 with cols 0..5=16'h0100 and others 0, then one cycle with image cols 0..5=16'h0100 valid, cols 6..13 invalid, psum_ins=0 -> next cycle psum_outs[0..5]=16'h0600 and [6..13]=0.
REQ-034 Invalid tag: valid_y=1, tag_row=12, all weights 16'h0100 -> a subsequent compute shows no change from the prior weights.
REQ-035 Overflow: all 12 rows with col 0 weight 16'h7F00, x=16'h0100, psum_in=0 -> psum_outs[0]=16'hF400 without the macro, 16'h7FFF with it.
REQ-036 Hold and collision: valid_x low -> outputs hold; valid_y and valid_x asserted together -> result uses old weights, and the next compute uses the new ones.
